count_down_en: RTL and testbench

//  Loadable down-counter with enable: the decrementing counterpart of the team's up-counter-with-enable.

---
 rtl/count_down_en.sv | 101 ++++++++++
 tb/tb_count_down_en.sv | 131 +++++++++++++
 2 files changed

// File: rtl/count_down_en.sv
// Loadable down-counter with enable, prescaler and terminal-count pulse.
// Build option: define COUNT_DOWN_AUTO_RELOAD_EN for periodic reload on terminal count.
module count_down_en #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadValue,
  input  logic             iEnable,
  output logic [WIDTH-1:0] oA,
  output logic             oBusy,
  output logic             oDone,
  output logic             oTerminal
);

  // state | meaning
  // IDLE  | after reset, enable ignored, count 0
  // RUN   | counting down on prescaled enabled ticks
  // DONE  | count exhausted, holds 0 until load or reset
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [PW-1:0]    ps, ps_nxt;
  logic             term, term_nxt;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload, reload_nxt;
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= IDLE;
      count <= '0;
      ps    <= '0;
      term  <= 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ps    <= ps_nxt;
      term  <= term_nxt;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload <= reload_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ps_nxt    = ps;
    term_nxt  = 1'b0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (iLoad) begin
      count_nxt = iLoadValue;
      ps_nxt    = '0;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
      reload_nxt = iLoadValue;
`endif
      if (iLoadValue == '0) begin
        state_nxt = DONE;
        term_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else if (state == RUN && iEnable) begin
      if (ps == PS_LAST) begin
        ps_nxt = '0;
        // RUN is only entered with a nonzero count, so the else arm is count==1
        if (count > WIDTH'(1)) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          term_nxt = 1'b1;
`ifdef COUNT_DOWN_AUTO_RELOAD_EN
          count_nxt = reload;
`else
          count_nxt = '0;
          state_nxt = DONE;
`endif
        end
      end else begin
        ps_nxt = ps + PW'(1);
      end
    end
  end

  assign oA        = count;
  assign oBusy     = (state == RUN);
  assign oDone     = (state == DONE);
  assign oTerminal = term;

endmodule

// File: tb/tb_count_down_en.sv
// Directed bench for count_down_en: PRESCALE=1 instance plus a PRESCALE=3 instance.
`timescale 1ns/1ps
module tb_count_down_en;

  logic       iClock = 1'b0;
  logic       iReset, iLoad, iEnable;
  logic [7:0] iLoadValue;
  logic [7:0] a1, a3;
  logic       busy1, done1, term1, busy3, done3, term3;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 iClock = ~iClock;

  count_down_en #(.WIDTH(8), .PRESCALE(1)) u_p1 (
    .iClock(iClock), .iReset(iReset), .iLoad(iLoad), .iLoadValue(iLoadValue),
    .iEnable(iEnable), .oA(a1), .oBusy(busy1), .oDone(done1), .oTerminal(term1));

  count_down_en #(.WIDTH(8), .PRESCALE(3)) u_p3 (
    .iClock(iClock), .iReset(iReset), .iLoad(iLoad), .iLoadValue(iLoadValue),
    .iEnable(iEnable), .oA(a3), .oBusy(busy3), .oDone(done3), .oTerminal(term3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  initial begin
    iReset = 1'b1; iLoad = 1'b0; iEnable = 1'b0; iLoadValue = 8'd0;
    step(); step();
    chk("rst_a", a1, 0); chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0); chk("rst_term", term1, 0);

    // idle ignores enable
    iReset = 1'b0; iEnable = 1'b1;
    step();
    chk("idle_a", a1, 0); chk("idle_busy", busy1, 0);

    // T1: reset during RUN with oA=5
    iEnable = 1'b0; iLoad = 1'b1; iLoadValue = 8'd5;
    step();
    chk("t1_load_a", a1, 5); chk("t1_load_busy", busy1, 1);
    iLoad = 1'b0; iReset = 1'b1; iEnable = 1'b1;
    step();
    chk("t1_a", a1, 0); chk("t1_busy", busy1, 0);
    chk("t1_done", done1, 0); chk("t1_term", term1, 0);
    iReset = 1'b0;

`ifndef COUNT_DOWN_AUTO_RELOAD_EN
    // T2: one-shot 3,2,1,0 and no wrap
    iLoad = 1'b1; iLoadValue = 8'd3; iEnable = 1'b1;
    step();
    chk("t2_a3", a1, 3); chk("t2_term3", term1, 0);
    iLoad = 1'b0;
    step(); chk("t2_a2", a1, 2);
    step(); chk("t2_a1", a1, 1); chk("t2_term1", term1, 0);
    step(); chk("t2_a0", a1, 0); chk("t2_term0", term1, 1);
    chk("t2_done0", done1, 1); chk("t2_busy0", busy1, 0);
    step(); chk("t2_term_off", term1, 0); chk("t2_done_hold", done1, 1);
    for (int i = 0; i < 3; i++) begin
      step(); chk("t2_nowrap", a1, 0);
    end
`else
    // T5: periodic reload 2,1,2,1,...
    iLoad = 1'b1; iLoadValue = 8'd2; iEnable = 1'b1;
    step();
    chk("t5_a2", a1, 2);
    iLoad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_a1", a1, 1); chk("t5_term_lo", term1, 0);
      step(); chk("t5_a2r", a1, 2); chk("t5_term_hi", term1, 1);
      chk("t5_busy", busy1, 1); chk("t5_done", done1, 0);
    end
`endif

    // T3: enable gating 4,3,3,3,2
    iEnable = 1'b0; iLoad = 1'b1; iLoadValue = 8'd4;
    step(); chk("t3_a4", a1, 4);
    iLoad = 1'b0;
    iEnable = 1'b1; step(); chk("t3_e1", a1, 3);
    iEnable = 1'b0; step(); chk("t3_e0a", a1, 3);
    step(); chk("t3_e0b", a1, 3);
    iEnable = 1'b1; step(); chk("t3_e1b", a1, 2);

    // T3 prescaler: load 2, terminal after 6 enabled cycles with a gap inserted
    iEnable = 1'b0; iLoad = 1'b1; iLoadValue = 8'd2;
    step(); chk("p3_load", a3, 2);
    iLoad = 1'b0; iEnable = 1'b1;
    step(); step(); chk("p3_pre", a3, 2);
    step(); chk("p3_tick1", a3, 1);
    iEnable = 1'b0; step(); chk("p3_gap", a3, 1);
    iEnable = 1'b1;
    step(); step(); chk("p3_term_lo", term3, 0); chk("p3_a_lo", a3, 1);
    step(); chk("p3_term_hi", term3, 1); chk("p3_a0", a3, 0);

    // T4: load 0
    iEnable = 1'b0; iLoad = 1'b1; iLoadValue = 8'd0;
    step();
    chk("t4_z_done", done1, 1); chk("t4_z_term", term1, 1);
    chk("t4_z_busy", busy1, 0); chk("t4_z_a", a1, 0);
    iLoad = 1'b0;
    step(); chk("t4_z_term_off", term1, 0); chk("t4_z_done_hold", done1, 1);

    // T4: load 7 on the terminal-tick cycle
    iLoad = 1'b1; iLoadValue = 8'd1; iEnable = 1'b1;
    step(); chk("t4_l1", a1, 1);
    iLoadValue = 8'd7;
    step();
    chk("t4_l7_a", a1, 7); chk("t4_l7_term", term1, 0); chk("t4_l7_busy", busy1, 1);
    iLoad = 1'b0;
    step(); chk("t4_l7_dec", a1, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
